// File: rtl/hb_boot_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hb_boot_pkg
// Brief    : Shared FSM state type and default geometry for the boot loader.
// Revision : 1.0 - initial release
// ============================================================================
package hb_boot_pkg;

    // Default ROM/RAM address width and the last byte address copied
    localparam int unsigned       DEF_ADDR_W    = 12;
    localparam logic [11:0]       DEF_LAST_ADDR = 12'hFFF;

    // Copy sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LATCH = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } boot_state_t;

endpackage : hb_boot_pkg
`default_nettype wire

// File: rtl/boot_addr_counter.sv
`default_nettype none
// ============================================================================
// Module   : boot_addr_counter
// Brief    : Clear/increment byte address counter with terminal-match flag.
//            Saturates at LAST so it can never wrap back to zero.
// Revision : 1.0 - initial release
// ============================================================================
module boot_addr_counter
    import hb_boot_pkg::*;
#(
    parameter int unsigned        ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  LAST   = ADDR_W'(DEF_LAST_ADDR)
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] count,
    output logic              at_last
);

    logic [ADDR_W-1:0] r_count;

    // Counter register: clear wins over increment; increment blocked at LAST
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !at_last) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count   = r_count;
    assign at_last = (r_count == LAST);

endmodule : boot_addr_counter
`default_nettype wire

// File: rtl/boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader_ctrl
// Brief    : Copies an EEPROM image byte by byte into RAM, keeps a mod-256
//            checksum, and holds the CPU in reset until the copy completes.
//            Every output is a flop; strobes are decoded from the next state
//            so they line up with the state they belong to.
// Revision : 1.0 - initial release
// ============================================================================
module boot_loader_ctrl
    import hb_boot_pkg::*;
#(
    parameter int unsigned        ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEF_LAST_ADDR),
    parameter int unsigned        ROM_WAIT  = 1
) (
    input  logic              clk,
    input  logic              rst_bar,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ce_bar,
    input  logic [7:0]        rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_cs_bar,
    output logic              ram_we_bar,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);

    // Final WAIT cycle index; unused when ROM_WAIT is zero
    localparam logic [2:0] c_wait_last = (ROM_WAIT == 0) ? 3'd0 : 3'(ROM_WAIT - 1);

    boot_state_t       r_state;
    boot_state_t       w_next;
    logic [2:0]        r_wait_cnt;
    logic [ADDR_W-1:0] w_count;
    logic              w_last;
    logic              w_clr;
    logic              w_inc;

    // Address counter restarts whenever the sequencer re-enters IDLE and
    // steps only on the WRITE -> ADDR transition
    assign w_clr = (w_next == ST_IDLE);
    assign w_inc = (r_state == ST_WRITE) && (w_next == ST_ADDR);

    boot_addr_counter #(
        .ADDR_W (ADDR_W),
        .LAST   (LAST_ADDR)
    ) u_addr_counter (
        .clk     (clk),
        .rst_bar (rst_bar),
        .clr     (w_clr),
        .inc     (w_inc),
        .count   (w_count),
        .at_last (w_last)
    );

    // The counter itself is a flop, so it drives the ROM address directly
    assign rom_addr = w_count;

    // State register
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = ST_ADDR;
            ST_ADDR:  w_next = (ROM_WAIT > 0) ? ST_WAIT : ST_LATCH;
            ST_WAIT:  if (r_wait_cnt == c_wait_last) w_next = ST_LATCH;
            ST_LATCH: w_next = ST_WRITE;
            ST_WRITE: w_next = w_last ? ST_DONE : ST_ADDR;
            ST_DONE:  if (start) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // EEPROM wait-cycle counter, counts cycles spent in WAIT
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Registered outputs; ROM data is captured on the edge entering LATCH so
    // RAM address/data are already valid throughout LATCH and WRITE
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            ram_addr   <= '0;
            ram_wdata  <= '0;
            checksum   <= '0;
            rom_ce_bar <= 1'b1;
            ram_cs_bar <= 1'b1;
            ram_we_bar <= 1'b1;
            cpu_hold   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            rom_ce_bar <= !((w_next == ST_ADDR) || (w_next == ST_WAIT) ||
                            (w_next == ST_LATCH));
            ram_cs_bar <= (w_next != ST_WRITE);
            ram_we_bar <= (w_next != ST_WRITE);
            cpu_hold   <= (w_next != ST_DONE);
            busy       <= (w_next != ST_DONE);
            done       <= (w_next == ST_DONE);
            if (w_next == ST_IDLE) begin
                checksum <= '0;
            end else if (w_next == ST_LATCH) begin
                ram_wdata <= rom_data;
                ram_addr  <= w_count;
                checksum  <= checksum + rom_data;
            end
        end
    end

endmodule : boot_loader_ctrl
`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_boot_loader_ctrl
// Brief    : Self-checking bench: three loader instances (4-byte image with
//            one wait state, 4-byte image with no wait state, full 4 KiB image)
//            against ROM models and a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boot_loader_ctrl;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Instance A: LAST_ADDR=3, ROM_WAIT=1
    logic        rst_a = 1'b0, start_a = 1'b0;
    logic [11:0] rom_addr_a, ram_addr_a;
    logic [7:0]  rom_data_a, ram_wdata_a, checksum_a;
    logic        rom_ce_bar_a, ram_cs_bar_a, ram_we_bar_a, cpu_hold_a, busy_a, done_a;
    logic [7:0]  rom_a [4];

    // Instance W0: LAST_ADDR=3, ROM_WAIT=0
    logic        rst_w0 = 1'b0, start_w0 = 1'b0;
    logic [11:0] rom_addr_w0, ram_addr_w0;
    logic [7:0]  rom_data_w0, ram_wdata_w0, checksum_w0;
    logic        rom_ce_bar_w0, ram_cs_bar_w0, ram_we_bar_w0, cpu_hold_w0, busy_w0, done_w0;

    // Instance B: LAST_ADDR=0xFFF, ROM_WAIT=1
    logic        rst_b = 1'b0, start_b = 1'b0;
    logic [11:0] rom_addr_b, ram_addr_b;
    logic [7:0]  rom_data_b, ram_wdata_b, checksum_b;
    logic        rom_ce_bar_b, ram_cs_bar_b, ram_we_bar_b, cpu_hold_b, busy_b, done_b;

    wr_t sb_q[$];
    int  n_wr_a = 0, n_wr_w0 = 0, n_wr_b = 0, n_bad_b = 0, n_bad_w0 = 0;
    int  exp_addr_b = 0;
    logic [11:0] last_addr_b = '0;

    function automatic logic [7:0] rom_b_fn(input logic [11:0] a);
        return a[7:0] ^ {4'h0, a[11:8]};
    endfunction

    function automatic logic [7:0] rom_w0_fn(input logic [11:0] a);
        return 8'h11 * ({6'd0, a[1:0]} + 8'd1);
    endfunction

    // ROM models drive zero while deselected so mistimed captures are visible
    assign rom_data_a  = rom_ce_bar_a  ? 8'h00 : rom_a[rom_addr_a[1:0]];
    assign rom_data_w0 = rom_ce_bar_w0 ? 8'h00 : rom_w0_fn(rom_addr_w0);
    assign rom_data_b  = rom_ce_bar_b  ? 8'h00 : rom_b_fn(rom_addr_b);

    boot_loader_ctrl #(.ADDR_W(12), .LAST_ADDR(12'd3), .ROM_WAIT(1)) u_dut_a (
        .clk(clk), .rst_bar(rst_a), .start(start_a),
        .rom_addr(rom_addr_a), .rom_ce_bar(rom_ce_bar_a), .rom_data(rom_data_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_cs_bar(ram_cs_bar_a),
        .ram_we_bar(ram_we_bar_a), .cpu_hold(cpu_hold_a), .busy(busy_a),
        .done(done_a), .checksum(checksum_a)
    );

    boot_loader_ctrl #(.ADDR_W(12), .LAST_ADDR(12'd3), .ROM_WAIT(0)) u_dut_w0 (
        .clk(clk), .rst_bar(rst_w0), .start(start_w0),
        .rom_addr(rom_addr_w0), .rom_ce_bar(rom_ce_bar_w0), .rom_data(rom_data_w0),
        .ram_addr(ram_addr_w0), .ram_wdata(ram_wdata_w0), .ram_cs_bar(ram_cs_bar_w0),
        .ram_we_bar(ram_we_bar_w0), .cpu_hold(cpu_hold_w0), .busy(busy_w0),
        .done(done_w0), .checksum(checksum_w0)
    );

    boot_loader_ctrl #(.ADDR_W(12), .LAST_ADDR(12'hFFF), .ROM_WAIT(1)) u_dut_b (
        .clk(clk), .rst_bar(rst_b), .start(start_b),
        .rom_addr(rom_addr_b), .rom_ce_bar(rom_ce_bar_b), .rom_data(rom_data_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_cs_bar(ram_cs_bar_b),
        .ram_we_bar(ram_we_bar_b), .cpu_hold(cpu_hold_b), .busy(busy_b),
        .done(done_b), .checksum(checksum_b)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_w0;
            default: return done_b;
        endcase
    endfunction

    // Counts rising edges until the selected instance shows done; optionally
    // pulses start_a for one cycle at a given edge count
    task automatic wait_done(input int sel, input int budget, input int pulse_at, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            start_a = (pulse_at != 0) && (cyc == pulse_at);
            if (done_of(sel)) break;
        end
        start_a = 1'b0;
        check($sformatf("done_within_budget_sel%0d", sel), {31'd0, done_of(sel)}, 32'd1);
    endtask

    task automatic check_reset_a(input string pfx);
        check({pfx, "_rom_addr"},   rom_addr_a,   0);
        check({pfx, "_ram_addr"},   ram_addr_a,   0);
        check({pfx, "_ram_wdata"},  ram_wdata_a,  0);
        check({pfx, "_checksum"},   checksum_a,   0);
        check({pfx, "_rom_ce_bar"}, rom_ce_bar_a, 1);
        check({pfx, "_ram_cs_bar"}, ram_cs_bar_a, 1);
        check({pfx, "_ram_we_bar"}, ram_we_bar_a, 1);
        check({pfx, "_cpu_hold"},   cpu_hold_a,   1);
        check({pfx, "_busy"},       busy_a,       1);
        check({pfx, "_done"},       done_a,       0);
    endtask

    task automatic push_image_a();
        for (int i = 0; i < 4; i++) sb_q.push_back('{addr: 12'(i), data: rom_a[i]});
    endtask

    // Scoreboard for instance A: every write cycle must match the next entry
    always @(negedge clk) begin
        if (rst_a && !ram_cs_bar_a && !ram_we_bar_a) begin
            wr_t e;
            n_wr_a++;
            check("a_write_while_rom_ce", rom_ce_bar_a, 1);
            if (sb_q.size() == 0) begin
                check("a_sb_unexpected_write", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                check("a_wr_addr", ram_addr_a, e.addr);
                check("a_wr_data", ram_wdata_a, e.data);
            end
        end
    end

    // Write monitor for instance W0
    always @(negedge clk) begin
        if (rst_w0 && !ram_cs_bar_w0 && !ram_we_bar_w0) begin
            if (ram_wdata_w0 != rom_w0_fn(ram_addr_w0) || ram_addr_w0 != 12'(n_wr_w0)) n_bad_w0++;
            n_wr_w0++;
        end
    end

    // Write monitor for instance B: strictly ascending addresses, matching data
    always @(negedge clk) begin
        if (rst_b && !ram_cs_bar_b && !ram_we_bar_b) begin
            if (ram_addr_b != 12'(exp_addr_b) || ram_wdata_b != rom_b_fn(ram_addr_b)) n_bad_b++;
            exp_addr_b++;
            n_wr_b++;
            last_addr_b = ram_addr_b;
        end
    end

    initial begin
        int   cyc;
        logic [7:0] sum_b;

        rom_a[0] = 8'h11; rom_a[1] = 8'h22; rom_a[2] = 8'h33; rom_a[3] = 8'h44;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_a("rst");

        // Basic copy with start pulses while busy (mid-copy and on last WRITE)
        push_image_a();
        @(negedge clk) rst_a = 1'b1;
        wait_done(0, 100, 5, cyc);
        check("a_done_cycle", cyc, 17);
        check("a_checksum", checksum_a, 8'hAA);
        check("a_sb_drained", sb_q.size(), 0);
        check("a_write_count", n_wr_a, 4);
        check("a_busy_in_done", busy_a, 0);
        check("a_hold_in_done", cpu_hold_a, 0);
        check("a_rom_ce_in_done", rom_ce_bar_a, 1);
        repeat (3) @(posedge clk);
        #1;
        check("a_done_held", done_a, 1);
        check("a_checksum_held", checksum_a, 8'hAA);

        // Start pulse on the last WRITE edge must be ignored
        rst_a = 1'b0;
        push_image_a();
        @(negedge clk) rst_a = 1'b1;
        wait_done(0, 100, 16, cyc);
        check("a_late_start_done_cycle", cyc, 17);
        repeat (2) @(posedge clk);
        #1;
        check("a_late_start_ignored", done_a, 1);
        check("a_late_start_sb", sb_q.size(), 0);

        // Recopy from DONE: checksum restarts, not accumulated
        push_image_a();
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("a_recopy_done_low", done_a, 0);
        check("a_recopy_busy", busy_a, 1);
        check("a_recopy_checksum_clr", checksum_a, 0);
        wait_done(0, 100, 0, cyc);
        check("a_recopy_cycles", cyc, 17);
        check("a_recopy_checksum", checksum_a, 8'hAA);
        check("a_recopy_sb", sb_q.size(), 0);

        // All-FF image: checksum wraps
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) rom_a[i] = 8'hFF;
        push_image_a();
        @(negedge clk) rst_a = 1'b1;
        wait_done(0, 100, 0, cyc);
        check("ff_done_cycle", cyc, 17);
        check("ff_checksum", checksum_a, 8'hFC);
        check("ff_sb", sb_q.size(), 0);

        // Reset asserted during WAIT of byte 2
        rst_a = 1'b0;
        rom_a[0] = 8'h11; rom_a[1] = 8'h22; rom_a[2] = 8'h33; rom_a[3] = 8'h44;
        sb_q.push_back('{addr: 12'd0, data: 8'h11});
        sb_q.push_back('{addr: 12'd1, data: 8'h22});
        @(negedge clk) rst_a = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_in_wait_addr", rom_addr_a, 2);
        check("abort_in_wait_ce", rom_ce_bar_a, 0);
        check("abort_checksum_before", checksum_a, 8'h33);
        #2 rst_a = 1'b0;
        #1;
        check_reset_a("abort");
        check("abort_sb_partial", sb_q.size(), 0);
        push_image_a();
        @(negedge clk) rst_a = 1'b1;
        wait_done(0, 100, 0, cyc);
        check("abort_restart_cycle", cyc, 17);
        check("abort_restart_checksum", checksum_a, 8'hAA);
        check("abort_restart_sb", sb_q.size(), 0);

        // Zero wait states: 3 cycles per byte
        @(negedge clk) rst_w0 = 1'b1;
        wait_done(1, 100, 0, cyc);
        check("w0_done_cycle", cyc, 13);
        check("w0_checksum", checksum_w0, 8'hAA);
        check("w0_writes", n_wr_w0, 4);
        check("w0_bad_writes", n_bad_w0, 0);

        // Full 4 KiB image: terminates at 0xFFF without wrapping
        sum_b = 8'h00;
        for (int i = 0; i < 4096; i++) sum_b = sum_b + rom_b_fn(12'(i));
        @(negedge clk) rst_b = 1'b1;
        wait_done(2, 20000, 0, cyc);
        check("big_done_cycle", cyc, 1 + 4096 * 4);
        check("big_checksum", checksum_b, sum_b);
        check("big_writes", n_wr_b, 4096);
        check("big_bad_writes", n_bad_b, 0);
        check("big_last_addr", last_addr_b, 12'hFFF);
        repeat (4) @(posedge clk);
        #1;
        check("big_no_wrap_addr", rom_addr_b, 12'hFFF);
        check("big_done_held", done_b, 1);
        check("big_no_extra_writes", n_wr_b, 4096);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_boot_loader_ctrl
`default_nettype wire

// File: doc/boot_loader_ctrl.md
BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 12, width of ROM/RAM address; LAST_ADDR, default 12'hFFF, final byte address copied; ROM_WAIT, default 1, EEPROM access wait cycles (0..7).
REQ-002 One clock; reset is asynchronous and active-low: `clk  in  1  rising-edge system clock`.
REQ-003 `rst_bar  in  1  asynchronous active-low reset`.
REQ-004 `start  in  1  reload request, sampled only in DONE`.
REQ-005 `rom_addr  out  ADDR_W  EEPROM byte address`.
REQ-006 `rom_ce_bar  out  1  EEPROM chip enable, active-low`.
REQ-007 `rom_data  in  8  EEPROM read data`.
REQ-008 `ram_addr  out  ADDR_W  RAM write address`.
REQ-009 `ram_wdata  out  8  RAM write data`.
REQ-010 `ram_cs_bar  out  1  RAM chip select, active-low`.
REQ-011 `ram_we_bar  out  1  RAM write enable, active-low`.
REQ-012 `cpu_hold  out  1  holds CPU phase counter and PC cleared while high`.
REQ-013 `busy  out  1  copy in progress`.
REQ-014 `done  out  1  image copied, CPU released`.
REQ-015 `checksum  out  8  mod-256 sum of copied bytes`.

Function
REQ-016 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-017 FSM states SHALL be IDLE, ADDR, WAIT, LATCH, WRITE, DONE.
REQ-018 IDLE: one cycle; address counter = 0, checksum = 0; then go to ADDR.
REQ-019 ADDR: rom_addr = counter, rom_ce_bar = 0; then go to WAIT if ROM_WAIT>0, else go to LATCH.
REQ-020 WAIT: hold rom_addr and rom_ce_bar = 0 for exactly ROM_WAIT cycles, then go to LATCH.
REQ-021 LATCH: capture rom_data into the data register; add it to checksum modulo 256 (carry discarded); ram_addr = counter.
REQ-022 WRITE: ram_cs_bar = 0, ram_we_bar = 0 for exactly one cycle; ram_addr and ram_wdata stable from LATCH through WRITE.
REQ-023 On exit from WRITE, go to DONE if counter == LAST_ADDR; otherwise increment counter and go to ADDR.
REQ-024 The counter SHALL never wrap; LAST_ADDR = 2^ADDR_W-1 terminates without incrementing.
REQ-025 Per-byte cost SHALL be ROM_WAIT+3 cycles; DONE SHALL be entered 1+(LAST_ADDR+1)*(ROM_WAIT+3) cycles after rst_bar deasserts.
REQ-026 In DONE: done = 1, busy = 0, cpu_hold = 0, rom_ce_bar = 1, ram_cs_bar = 1, ram_we_bar = 1, checksum held.
REQ-027 In all states other than DONE: busy = 1, cpu_hold = 1, done = 0.
REQ-028 start high in DONE SHALL go to IDLE on the next edge; checksum restarts from 0 and is not accumulated.
REQ-029 start SHALL be ignored in every state except DONE.
REQ-030 rom_ce_bar SHALL be 1 in IDLE, WRITE, and DONE.
REQ-031 ram_cs_bar and ram_we_bar SHALL be 1 in every state except WRITE.

Reset
REQ-032 rst_bar low SHALL immediately force: state IDLE, counter 0, rom_addr 0, ram_addr 0, ram_wdata 0, checksum 0, rom_ce_bar 1, ram_cs_bar 1, ram_we_bar 1, cpu_hold 1, busy 1, done 0.
REQ-033 Reset mid-copy SHALL abort without completing the pending RAM write; copying restarts at address 0 after release.

Structure
REQ-034 Package hb_boot_pkg SHALL hold the FSM state typedef and the default ADDR_W/LAST_ADDR constants.
REQ-035 One sub-module, boot_addr_counter, SHALL provide the ADDR_W-bit clear/increment counter with a terminal-match flag.

Verification
REQ-036 LAST_ADDR=3, ROM_WAIT=1, ROM = 11,22,33,44 -> four one-cycle writes to addresses 0..3 with the matching data; done rises 17 cycles after reset release; checksum = 0xAA.
REQ-037 ROM = FF,FF,FF,FF, LAST_ADDR=3 -> checksum = 0xFC (wrap, carry discarded).
REQ-038 ROM_WAIT=0, LAST_ADDR=3 -> 3 cycles per byte; done at cycle 13.
REQ-039 rst_bar low during WAIT of byte 2 -> all outputs at reset values asynchronously; no write to address 2; after release, rewrite starts at address 0.
REQ-040 start pulsed during busy -> ignored; start pulsed in DONE -> full recopy, done low for the duration, final checksum 0xAA (not 0x54).
REQ-041 LAST_ADDR=0xFFF, ROM_WAIT=1 -> final write to 0xFFF; counter never wraps to 0; done at cycle 1+4096*4.
